sal_dfi_mem_responder: RTL

- DFI-side responder. It terminates the controller's DFI control, write and read channels, like a minimal PHY+DRAM model.
- It decodes ACT/PRE/RD/WR commands and tracks the open row per bank.
- It stores write bursts into a small masked memory and returns read bursts with fixed PHY read latency.
- Used as the DFI endpoint in controller-level simulation and FPGA bring-up. It flags protocol violations in sticky error bits.

---
 rtl/sal_dfi_mem_responder.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/sal_dfi_mem_responder.sv
// DFI endpoint model: decodes ACT/PRE/RD/WR, tracks open rows per bank, stores masked write
// bursts and returns read bursts after a fixed PHY read latency. Protocol violations are sticky.

module sal_dfi_cmd_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     slot_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = slot_q[rd_ptr_q];

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= bump(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= bump(rd_ptr_q);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) slot_q[wr_ptr_q] <= push_data_i;
    end
endmodule

module sal_dfi_mem_responder #(
    parameter int BK_CNT         = 8,
    parameter int BA_W           = 3,
    parameter int ADDR_W         = 16,
    parameter int ROW_IDX_W      = 2,
    parameter int COL_W          = 6,
    parameter int DATA_W         = 64,
    parameter int BURST_LEN      = 4,
    parameter int CMD_FIFO_DEPTH = 4,
    parameter int PHY_RDLAT      = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dfi_cs_n,
    input  logic                dfi_ras_n,
    input  logic                dfi_cas_n,
    input  logic                dfi_we_n,
    input  logic [BA_W-1:0]     dfi_bank,
    input  logic [ADDR_W-1:0]   dfi_address,
    input  logic                dfi_wrdata_en,
    input  logic [DATA_W-1:0]   dfi_wrdata,
    input  logic [DATA_W/8-1:0] dfi_wrdata_mask,
    input  logic                dfi_rddata_en,
    output logic [DATA_W-1:0]   dfi_rddata,
    output logic                dfi_rddata_valid,
    output logic [3:0]          err_o
);
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int IDX_W  = BA_W + ROW_IDX_W + COL_W;
    localparam int BYTES  = DATA_W / 8;

    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_WR  = 3'b100;

    logic [2:0]        cmd_code;
    logic              is_act, is_pre, is_rd, is_wr;
    logic [BK_CNT-1:0] open_q;
    logic [ADDR_W-1:0] open_row_q [BK_CNT];
    logic [COL_W-1:0]  col_base;
    logic [IDX_W-1:0]  cmd_entry;

    assign cmd_code  = {dfi_ras_n, dfi_cas_n, dfi_we_n};
    assign is_act    = !dfi_cs_n && (cmd_code == CMD_ACT);
    assign is_pre    = !dfi_cs_n && (cmd_code == CMD_PRE);
    assign is_rd     = !dfi_cs_n && (cmd_code == CMD_RD);
    assign is_wr     = !dfi_cs_n && (cmd_code == CMD_WR);
    assign col_base  = dfi_address[COL_W-1:0] & ~COL_W'(BURST_LEN - 1);
    // A closed bank still queues its stale row so the data path never stalls.
    assign cmd_entry = {dfi_bank, open_row_q[dfi_bank][ROW_IDX_W-1:0], col_base};

    always_ff @(posedge clk) begin
        if (rst) begin
            open_q <= '0;
            for (int b = 0; b < BK_CNT; b++) open_row_q[b] <= '0;
        end else if (is_act) begin
            open_q[dfi_bank]     <= 1'b1;
            open_row_q[dfi_bank] <= dfi_address;
        end else if (is_pre) begin
            if (dfi_address[10]) open_q <= '0;
            else                 open_q[dfi_bank] <= 1'b0;
        end
    end

    logic [IDX_W-1:0]  wr_head, rd_head;
    logic              wr_empty, wr_full, rd_empty, rd_full;
    logic              wr_beat, rd_beat, wr_last, rd_last, wr_pop, rd_pop;
    logic [BEAT_W-1:0] wr_beat_q, rd_beat_q;
    logic [IDX_W-1:0]  wr_addr, rd_addr;

    assign wr_beat = dfi_wrdata_en && !wr_empty;
    assign rd_beat = dfi_rddata_en && !rd_empty;
    assign wr_last = (wr_beat_q == BEAT_W'(BURST_LEN - 1));
    assign rd_last = (rd_beat_q == BEAT_W'(BURST_LEN - 1));
    assign wr_pop  = wr_beat && wr_last;
    assign rd_pop  = rd_beat && rd_last;
    assign wr_addr = {wr_head[IDX_W-1:COL_W], wr_head[COL_W-1:0] | COL_W'(wr_beat_q)};
    assign rd_addr = {rd_head[IDX_W-1:COL_W], rd_head[COL_W-1:0] | COL_W'(rd_beat_q)};

    sal_dfi_cmd_fifo #(.W(IDX_W), .DEPTH(CMD_FIFO_DEPTH)) u_wr_fifo (
        .clk(clk), .rst(rst), .push_i(is_wr), .push_data_i(cmd_entry),
        .pop_i(wr_pop), .head_o(wr_head), .empty_o(wr_empty), .full_o(wr_full)
    );

    sal_dfi_cmd_fifo #(.W(IDX_W), .DEPTH(CMD_FIFO_DEPTH)) u_rd_fifo (
        .clk(clk), .rst(rst), .push_i(is_rd), .push_data_i(cmd_entry),
        .pop_i(rd_pop), .head_o(rd_head), .empty_o(rd_empty), .full_o(rd_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_beat_q <= '0;
            rd_beat_q <= '0;
        end else begin
            if (wr_beat) wr_beat_q <= wr_last ? '0 : wr_beat_q + BEAT_W'(1);
            if (rd_beat) rd_beat_q <= rd_last ? '0 : rd_beat_q + BEAT_W'(1);
        end
    end

    logic [DATA_W-1:0] mem [2**IDX_W];

    // NOTE: storage is deliberately left out of reset so contents survive it and map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_beat && !rst) begin
            for (int b = 0; b < BYTES; b++) begin
                if (!dfi_wrdata_mask[b]) mem[wr_addr][b*8 +: 8] <= dfi_wrdata[b*8 +: 8];
            end
        end
    end

    logic [PHY_RDLAT-1:0] rd_vld_q;
    logic [DATA_W-1:0]    rd_pipe_q [PHY_RDLAT];
    logic [DATA_W-1:0]    rd_word_d;

    // Read samples memory before this edge's write lands, so a same-word collision sees old data.
    assign rd_word_d = rd_beat ? mem[rd_addr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q <= '0;
            for (int i = 0; i < PHY_RDLAT; i++) rd_pipe_q[i] <= '0;
        end else begin
            rd_vld_q[0]  <= dfi_rddata_en;
            rd_pipe_q[0] <= rd_word_d;
            for (int i = 1; i < PHY_RDLAT; i++) begin
                rd_vld_q[i]  <= rd_vld_q[i-1];
                rd_pipe_q[i] <= rd_pipe_q[i-1];
            end
        end
    end

    assign dfi_rddata_valid = rd_vld_q[PHY_RDLAT-1];
    assign dfi_rddata       = rd_pipe_q[PHY_RDLAT-1];

    logic [3:0] err_q, err_d;

    // NOTE: the combinational block starts from a full default so no latch can be inferred.
    always_comb begin
        err_d = err_q;
        if ((is_rd || is_wr) && !open_q[dfi_bank]) err_d[0] = 1'b1;
        if (is_act && open_q[dfi_bank])            err_d[1] = 1'b1;
        if ((is_rd && rd_full && !rd_pop) || (is_wr && wr_full && !wr_pop)) err_d[2] = 1'b1;
        if ((dfi_rddata_en && rd_empty) || (dfi_wrdata_en && wr_empty))     err_d[3] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) err_q <= '0;
        else     err_q <= err_d;
    end

    assign err_o = err_q;
endmodule
